// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-side PC sequencer.
// Holds the sequencer state encoding, the NOP word and the default fetch vectors.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC_DEF  = 32'h0000_0100;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_seq_redirect_det.sv
// Combinational decode of execute-stage redirects: taken check, fetch target, misalignment.
// A misaligned target is replaced by the trap vector.
module redirect_det
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] TRAP_PC = TRAP_PC_DEF
) (
  input  logic        ex_valid,
  input  logic        ex_br_sig,
  input  logic [31:0] ex_new_pc,
  input  logic [31:0] ex_pc_plus4,
  output logic        redirect,
  output logic        misalign,
  output logic [31:0] target
);

  // Predict-not-taken: only a resolved PC that differs from the fall-through redirects.
  always_comb begin
    redirect = ex_valid & ex_br_sig & (ex_new_pc != ex_pc_plus4);
    misalign = redirect & is_misaligned(ex_new_pc);
    target   = is_misaligned(ex_new_pc) ? TRAP_PC : ex_new_pc;
  end

endmodule

// File: rtl/pc_seq.sv
// Fetch PC sequencer: owns the fetch PC, runs the imem handshake with one request
// outstanding, and applies execute-stage redirects with a registered flush pulse.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] TRAP_PC  = TRAP_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_br_sig,
  input  logic [31:0] ex_new_pc,
  input  logic [31:0] ex_pc_plus4,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        flush,
  output logic        misalign
);

  state_t      state_r;
  state_t      state_nxt;
  logic [31:0] pc_r;
  logic [31:0] pc_nxt;
  logic        drop_r;
  logic        drop_nxt;
  logic        ifv_keep_s;
  logic        ifv_nxt;
  logic [31:0] instr_nxt;
  logic [31:0] ifpc_nxt;
  logic        redirect_s;
  logic        misalign_s;
  logic [31:0] target_s;

  redirect_det #(
    .TRAP_PC(TRAP_PC)
  ) u_redirect_det (
    .ex_valid   (ex_valid),
    .ex_br_sig  (ex_br_sig),
    .ex_new_pc  (ex_new_pc),
    .ex_pc_plus4(ex_pc_plus4),
    .redirect   (redirect_s),
    .misalign   (misalign_s),
    .target     (target_s)
  );

  // Next-state, next-PC and IF/ID output selection.
  always_comb begin
    state_nxt  = state_r;
    pc_nxt     = pc_r;
    drop_nxt   = drop_r;
    ifv_keep_s = if_valid & stall;
    instr_nxt  = if_instr;
    ifpc_nxt   = if_pc;

    case (state_r)
      S_BOOT: begin
        state_nxt = S_REQ;
        if (redirect_s) begin
          pc_nxt = target_s;
        end else begin
          pc_nxt = pc_r;
        end
      end

      S_REQ: begin
        if (redirect_s) begin
          pc_nxt = target_s;
          // The old address was already accepted; its response must be discarded.
          if (imem_gnt) begin
            drop_nxt  = 1'b1;
            state_nxt = S_DRAIN;
          end else begin
            state_nxt = S_REQ;
          end
        end else if (imem_gnt) begin
          pc_nxt    = pc_r + 32'd4;
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_REQ;
        end
      end

      S_WAIT: begin
        if (redirect_s) begin
          pc_nxt = target_s;
          if (imem_rvalid) begin
            state_nxt = S_REQ;
          end else begin
            drop_nxt  = 1'b1;
            state_nxt = S_DRAIN;
          end
        end else if (imem_rvalid) begin
          instr_nxt  = imem_rdata;
          ifpc_nxt   = pc_r - 32'd4;
          ifv_keep_s = 1'b1;
          state_nxt  = stall ? S_HOLD : S_REQ;
        end else begin
          state_nxt = S_WAIT;
        end
      end

      S_DRAIN: begin
        if (redirect_s) begin
          pc_nxt = target_s;
        end else begin
          pc_nxt = pc_r;
        end
        if (imem_rvalid) begin
          drop_nxt  = 1'b0;
          state_nxt = S_REQ;
        end else begin
          state_nxt = S_DRAIN;
        end
      end

      S_HOLD: begin
        if (redirect_s) begin
          pc_nxt    = target_s;
          state_nxt = S_REQ;
        end else if (!stall) begin
          state_nxt = S_REQ;
        end else begin
          state_nxt = S_HOLD;
        end
      end

      default: begin
        state_nxt = S_BOOT;
        pc_nxt    = RESET_PC;
        drop_nxt  = 1'b0;
      end
    endcase

    ifv_nxt = redirect_s ? 1'b0 : ifv_keep_s;
  end

  // State, PC and registered outputs; request/address track the next state so they are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_BOOT;
      pc_r      <= RESET_PC;
      drop_r    <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      if_valid  <= 1'b0;
      if_instr  <= NOP_INSTR;
      if_pc     <= 32'h0000_0000;
      flush     <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      pc_r      <= pc_nxt;
      drop_r    <= drop_nxt;
      imem_req  <= (state_nxt == S_REQ);
      imem_addr <= pc_nxt;
      if_valid  <= ifv_nxt;
      if_instr  <= instr_nxt;
      if_pc     <= ifpc_nxt;
      flush     <= redirect_s;
      misalign  <= misalign_s;
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: transaction-level reference model plus directed
// literal checks, followed by randomized handshake/redirect/stall traffic.
module tb_pc_seq;
  import pc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_br_sig = 1'b0, stall = 1'b0;
  logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] ex_new_pc = 32'h0, ex_pc_plus4 = 32'h0, imem_rdata = 32'h0;
  logic        imem_req, if_valid, flush, misalign;
  logic [31:0] imem_addr, if_instr, if_pc;
  logic        w_req, w_ifv, w_flush, w_mis;
  logic [31:0] w_addr, w_instr, w_ifpc;

  int total = 0;
  int bad = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_ifpc[$];
  logic [31:0] w_q[$];
  logic [31:0] last_gnt, last_rdata, held;

  // reference model state (transaction view: outstanding fetch, killed fetch, held instruction)
  logic        m_req, m_ifv, m_flush, m_mis, m_out, m_kill, m_hold, m_boot, env_pend;
  logic [31:0] m_addr, m_instr, m_ifpc, m_pc, m_gaddr;

  always #5 clk = ~clk;

  pc_seq dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_br_sig(ex_br_sig),
    .ex_new_pc(ex_new_pc), .ex_pc_plus4(ex_pc_plus4), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .flush(flush), .misalign(misalign)
  );

  pc_seq #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_br_sig(ex_br_sig),
    .ex_new_pc(ex_new_pc), .ex_pc_plus4(ex_pc_plus4), .stall(stall),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(w_ifv),
    .if_instr(w_instr), .if_pc(w_ifpc), .flush(w_flush), .misalign(w_mis)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_pc = 32'h0; m_addr = 32'h0; m_req = 1'b0; m_ifv = 1'b0;
    m_instr = 32'h0000_0013; m_ifpc = 32'h0; m_flush = 1'b0; m_mis = 1'b0;
    m_out = 1'b0; m_kill = 1'b0; m_hold = 1'b0; m_gaddr = 32'h0; env_pend = 1'b0;
  endtask

  task automatic compare();
    chk("imem_req", {31'h0, imem_req}, {31'h0, m_req});
    if (m_req) chk("imem_addr", imem_addr, m_addr);
    chk("if_valid", {31'h0, if_valid}, {31'h0, m_ifv});
    chk("if_instr", if_instr, m_instr);
    chk("if_pc", if_pc, m_ifpc);
    chk("flush", {31'h0, flush}, {31'h0, m_flush});
    chk("misalign", {31'h0, misalign}, {31'h0, m_mis});
  endtask

  // Advance the model one clock from the inputs currently driven.
  task automatic model_next(input logic v, br, input logic [31:0] np, p4, input logic st, g);
    logic redir, mis, grant, resp, cap, n_out, n_kill;
    logic [31:0] tgt;
    redir = v & br & (np != p4);
    mis   = (np[1:0] != 2'b00);
    tgt   = mis ? 32'h0000_0100 : np;
    grant = m_req & g;
    resp  = imem_rvalid;
    m_flush = redir;
    m_mis   = redir & mis;
    if (m_boot) begin
      m_boot = 1'b0;
      if (redir) m_pc = tgt;
    end else begin
      cap    = resp & ~m_kill & ~redir;
      n_out  = grant ? 1'b1 : (resp ? 1'b0 : m_out);
      n_kill = (redir & grant) ? 1'b1 : (resp ? 1'b0 : (m_kill | (redir & m_out)));
      m_ifv  = redir ? 1'b0 : (cap ? 1'b1 : (st & m_ifv));
      if (cap) begin
        m_instr = imem_rdata;
        m_ifpc  = m_gaddr;
      end
      if (grant) m_gaddr = m_pc;
      m_pc   = redir ? tgt : (grant ? m_pc + 32'd4 : m_pc);
      m_hold = redir ? 1'b0 : (cap ? st : (m_hold & st));
      m_out  = n_out;
      m_kill = n_kill;
    end
    m_req  = ~m_out & ~m_hold;
    m_addr = m_pc;
  endtask

  // One cycle: check at negedge, drive inputs, update model, cross the posedge.
  task automatic step(input logic v, br, input logic [31:0] np, p4, input logic st, g, rv);
    compare();
    if (if_valid) q_ifpc.push_back(if_pc);
    ex_valid = v; ex_br_sig = br; ex_new_pc = np; ex_pc_plus4 = p4; stall = st;
    imem_gnt = g; imem_rvalid = rv & env_pend; imem_rdata = $urandom;
    last_rdata = imem_rdata;
    model_next(v, br, np, p4, st, g);
    if (imem_req && imem_gnt) begin
      q_addr.push_back(imem_addr);
      last_gnt = imem_addr;
    end
    if (w_req && imem_gnt) w_q.push_back(w_addr);
    env_pend = (env_pend & ~imem_rvalid) | (imem_req & imem_gnt);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic g, rv);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, g, rv);
  endtask

  task automatic go_wait();
    int n = 0;
    while (!(m_out && !m_kill) && n < 12) begin
      idle(1'b1, 1'b1);
      n++;
    end
    if (!(m_out && !m_kill)) begin
      total++; bad++;
      $display("FAIL reach_wait: got no outstanding fetch after %0d cycles, expected one", n);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_ifv", {31'h0, if_valid}, 32'h0);
    chk("rst_instr", if_instr, 32'h0000_0013);
    chk("rst_ifpc", if_pc, 32'h0);
    rst_n = 1'b1;

    // sequential fetch, single-cycle imem
    repeat (10) idle(1'b1, 1'b1);
    if (q_addr.size() >= 3 && q_ifpc.size() >= 3 && w_q.size() >= 2) begin
      chk("seq_addr0", q_addr[0], 32'h0);
      chk("seq_addr1", q_addr[1], 32'h4);
      chk("seq_addr2", q_addr[2], 32'h8);
      chk("seq_ifpc0", q_ifpc[0], 32'h0);
      chk("seq_ifpc1", q_ifpc[1], 32'h4);
      chk("seq_ifpc2", q_ifpc[2], 32'h8);
      chk("wrap_addr0", w_q[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", w_q[1], 32'h0);
    end else begin
      chk("seq_count", q_addr.size(), 32'd3);
    end

    // taken branch while waiting for data
    go_wait();
    step(1'b1, 1'b1, 32'h40, 32'h10, 1'b0, 1'b1, 1'b0);
    chk("tk_flush", {31'h0, flush}, 32'h1);
    chk("tk_ifv", {31'h0, if_valid}, 32'h0);
    go_wait();
    chk("tk_addr", last_gnt, 32'h40);
    chk("tk_flush_end", {31'h0, flush}, 32'h0);

    // not-taken branch: capture continues
    step(1'b1, 1'b1, 32'h0C, 32'h0C, 1'b0, 1'b1, 1'b1);
    chk("nt_flush", {31'h0, flush}, 32'h0);
    chk("nt_ifpc", if_pc, 32'h40);
    go_wait();
    chk("nt_addr", last_gnt, 32'h44);

    // misaligned jump target traps
    step(1'b1, 1'b1, 32'h42, 32'h20, 1'b0, 1'b1, 1'b0);
    chk("mis_pulse", {31'h0, misalign}, 32'h1);
    chk("mis_flush", {31'h0, flush}, 32'h1);
    go_wait();
    chk("mis_addr", last_gnt, 32'h100);

    // stall after fetch, then redirect during the stall
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    held = last_rdata;
    for (int i = 0; i < 3; i++) begin
      chk("hold_ifv", {31'h0, if_valid}, 32'h1);
      chk("hold_ifpc", if_pc, 32'h100);
      chk("hold_instr", if_instr, held);
      chk("hold_req", {31'h0, imem_req}, 32'h0);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    end
    step(1'b1, 1'b1, 32'h80, 32'h10, 1'b1, 1'b0, 1'b0);
    chk("hr_ifv", {31'h0, if_valid}, 32'h0);
    chk("hr_flush", {31'h0, flush}, 32'h1);
    chk("hr_addr", imem_addr, 32'h80);
    go_wait();
    chk("hr_gnt", last_gnt, 32'h80);

    // asynchronous reset in the middle of a fetch
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req", {31'h0, imem_req}, 32'h0);
    chk("ar_addr", imem_addr, 32'h0);
    chk("ar_ifv", {31'h0, if_valid}, 32'h0);
    chk("ar_instr", if_instr, 32'h0000_0013);
    chk("ar_ifpc", if_pc, 32'h0);
    chk("ar_flush", {31'h0, flush}, 32'h0);
    ex_valid = 1'b0; ex_br_sig = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; stall = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] p4, np;
      int sel;
      p4  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      sel = $urandom_range(0, 3);
      np  = (sel == 0) ? p4 :
            (sel == 2) ? {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))} :
                         {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      step(($urandom_range(0, 9) < 3), $urandom_range(0, 1) == 1, np, p4,
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
